axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Round-robin arbiter that shares one AXI-stream sink between NUM_CH stream sources. Selected source's data, valid and last pass straight to the master port, and the master's ready returns only to that source. The block sits upstream of the memory-mapped AXI-stream slave interface at segment 0xe4 / class 0xa9, so several producers can feed the CPU-visible receive port. A per-channel enable mask lets software fence sources off.

## Interface
- NUM_CH, 4: number of requesting stream sources, 2..16.
- AXIS_DATA_WIDTH, 8: tdata width per channel.
- GRANT_W, $clog2(NUM_CH): width of the grant index (derived, not overridden).

Ports:
- axis_aclk_i  in  1  single clock; all logic rising-edge.
- axis_aresetn_i  in  1  asynchronous active-low reset.
- ch_enable_i  in  NUM_CH  per-channel arbitration mask; 1 = eligible.
- s_axis_tvalid_i  in  NUM_CH  per-source valid.
- s_axis_tlast_i  in  NUM_CH  per-source last.
- s_axis_tdata_i  in  NUM_CH*AXIS_DATA_WIDTH  channel k at bits [k*W +: W].
- s_axis_tready_o  out  NUM_CH  per-source ready; only the granted bit may be 1.
- m_axis_tvalid_o  out  1  muxed valid.
- m_axis_tlast_o  out  1  muxed last.
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  muxed data.
- m_axis_tready_i  in  1  sink ready.
- grant_valid_o  out  1  a channel currently holds the grant.
- grant_o  out  GRANT_W  index of the granted channel.

## Operation
- State machine: IDLE, GRANT.
- IDLE:
  - Request vector is s_axis_tvalid_i & ch_enable_i.
  - If non-zero, pick the first set bit searching upward from last_grant+1, wrapping modulo NUM_CH.
  - Register the pick into grant_o and last_grant; go to GRANT.
  - If zero, stay in IDLE.
- GRANT:
  - m_axis_tvalid_o = s_axis_tvalid_i[grant_o].
  - m_axis_tdata_o and m_axis_tlast_o are muxed from the granted channel.
  - s_axis_tready_o[grant_o] = m_axis_tready_i; all other bits are 0.
- Transfer occurs when m_axis_tvalid_o and m_axis_tready_i are both 1.
- Release: on a transfer meeting the release condition (see Configuration), return to IDLE next cycle.
- Outside GRANT: m_axis_tvalid_o, m_axis_tlast_o and all s_axis_tready_o bits are 0; m_axis_tdata_o is 0.
- Mask changes:
  - Take effect at the next arbitration only.
  - Clearing the granted channel's enable bit does not revoke a grant already held.
- A granted source that drops tvalid keeps the grant; no timeout.

## Timing
- Reset values:
  - state = IDLE, grant_valid_o = 0, grant_o = 0.
  - last_grant = NUM_CH-1, so channel 0 wins first.
  - All stream outputs are 0.
- Arbitration latency: one cycle from request seen in IDLE to grant_valid_o=1.
- Data path is combinational through the mux; no added latency once granted.
- Back-to-back packets always pass through at least one IDLE cycle, so there are zero-transfer bubbles between grants.
- Simultaneous requests: the round-robin order decides. A channel just released has lowest priority at the next arbitration.
- Single eligible channel: re-granted on every arbitration.
- Reset asserted mid-packet: all outputs drop to reset values immediately (asynchronously). The partial packet is abandoned, and sources must tolerate this.

## Configuration
- AXIS_ARB_PKT_LOCK_EN defined: the grant is held until a transfer with tlast=1 (packet-atomic arbitration).
- Macro undefined: the grant is released after every single transfer (beat-level interleave), and tlast is ignored for arbitration but still forwarded.

## Structure
- Shared package axis_arb_pkg contains:
  - State enum (ARB_IDLE, ARB_GRANT).
  - Default NUM_CH and AXIS_DATA_WIDTH constants.
  - The wrap-around index increment function.
- One sub-module, axis_rr_picker: purely combinational. Inputs are the request vector and last_grant; outputs are pick_valid and pick_idx. It is reused by any future arbiter in the design.

## Test plan
- Reset release, NUM_CH=4, channels 0 and 2 valid with tlast=1 on every beat, sink ready:
  - Grants go 0, 2, 0, 2.
  - grant_valid_o rises exactly one cycle after reset deassertion + request.
- AXIS_ARB_PKT_LOCK_EN defined; channel 1 sends a 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) while channel 3 requests:
  - Master sees 0x11, 0x22, 0x33 contiguous.
  - Channel 3 granted after one IDLE cycle.
  - s_axis_tready_o[3] stays 0 throughout channel 1's packet.
- Same stimulus with macro undefined:
  - Master sees 0x11 (ch1), ch3 beat, 0x22 (ch1), ch3 beat, ...
  - Alternation holds with an IDLE bubble between each beat.
- ch_enable_i=4'b1011 with all channels valid:
  - Channel 2 is never granted.
  - Clearing bit 1 while channel 1 is granted mid-packet lets channel 1 complete its packet.
- Sink stalls with m_axis_tready_i=0 for 5 cycles during a grant:
  - Granted s_axis_tready_o bit is 0 during the stall.
  - Data held; no release, no lost or duplicated beat.
- axis_aresetn_i pulsed low while channel 2 is mid-packet:
  - All outputs are 0 in the same cycle.
  - After release, channel 0 wins the first arbitration if valid.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the AXI-stream arbiters:
//   - arb_state_e    : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   - ARB_DEF_NUM_CH : default number of stream sources
//   - ARB_DEF_DATA_W : default tdata width per channel
//   - arb_wrap_inc() : index increment that wraps modulo the channel count
// -----------------------------------------------------------------------------
package axis_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int unsigned ARB_DEF_NUM_CH = 4;
   localparam int unsigned ARB_DEF_DATA_W = 8;

   // Next index in round-robin order: n-1 wraps back to 0.
   function automatic int unsigned arb_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end
      return idx + 32'd1;
   endfunction

endpackage : axis_arb_pkg

// File: rtl/axis_rr_picker.sv
// -----------------------------------------------------------------------------
// axis_rr_picker
// Purely combinational round-robin pick: returns the first set request bit
// searching upward from i_last_grant+1, wrapping modulo NUM_CH. The channel
// that won last time is therefore examined last.
//
// Ports:
//   i_req          [NUM_CH]   request vector
//   i_last_grant   [GRANT_W]  index granted at the previous arbitration
//   o_pick_valid   [1]        at least one request bit is set
//   o_pick_idx     [GRANT_W]  winning index (0 when o_pick_valid = 0)
// -----------------------------------------------------------------------------
module axis_rr_picker
   import axis_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH  = ARB_DEF_NUM_CH,
   localparam int unsigned GRANT_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0]  i_req,
   input  logic [GRANT_W-1:0] i_last_grant,
   output logic               o_pick_valid,
   output logic [GRANT_W-1:0] o_pick_idx
);

   always_comb begin
      int unsigned w_cand;
      logic        w_found;
      // NOTE: every variable written here gets a value before any branch, so
      // no path leaves one unassigned and no latch is inferred.
      w_found      = 1'b0;
      o_pick_idx   = '0;
      w_cand       = 32'(i_last_grant);
      for (int unsigned off = 0; off < NUM_CH; off++) begin
         w_cand = arb_wrap_inc(w_cand, NUM_CH);
         if (!w_found && i_req[GRANT_W'(w_cand)]) begin
            w_found    = 1'b1;
            o_pick_idx = GRANT_W'(w_cand);
         end
      end
      o_pick_valid = w_found;
   end

endmodule : axis_rr_picker

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Round-robin arbiter sharing one AXI-stream sink between NUM_CH sources.
// In IDLE the enabled, valid sources are arbitrated; the winner is held in
// GRANT where its valid/last/data pass combinationally to the master port and
// the master's ready returns only to it.
//
// Build option:
//   AXIS_ARB_PKT_LOCK_EN  defined   : grant held until a transfer with tlast=1
//                         undefined : grant released after every transfer
//
// Ports:
//   axis_aclk_i      [1]         clock, rising edge
//   axis_aresetn_i   [1]         asynchronous active-low reset
//   ch_enable_i      [NUM_CH]    arbitration mask, 1 = eligible
//   s_axis_tvalid_i  [NUM_CH]    per-source valid
//   s_axis_tlast_i   [NUM_CH]    per-source last
//   s_axis_tdata_i   [NUM_CH*W]  channel k at bits [k*W +: W]
//   s_axis_tready_o  [NUM_CH]    per-source ready, only the granted bit active
//   m_axis_tvalid_o  [1]         muxed valid
//   m_axis_tlast_o   [1]         muxed last
//   m_axis_tdata_o   [W]         muxed data
//   m_axis_tready_i  [1]         sink ready
//   grant_valid_o    [1]         a channel holds the grant
//   grant_o          [GRANT_W]   granted channel index
// -----------------------------------------------------------------------------
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int unsigned NUM_CH          = ARB_DEF_NUM_CH,
   parameter  int unsigned AXIS_DATA_WIDTH = ARB_DEF_DATA_W,
   localparam int unsigned GRANT_W         = $clog2(NUM_CH)
) (
   input  logic                              axis_aclk_i,
   input  logic                              axis_aresetn_i,
   input  logic [NUM_CH-1:0]                 ch_enable_i,
   input  logic [NUM_CH-1:0]                 s_axis_tvalid_i,
   input  logic [NUM_CH-1:0]                 s_axis_tlast_i,
   input  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
   output logic [NUM_CH-1:0]                 s_axis_tready_o,
   output logic                              m_axis_tvalid_o,
   output logic                              m_axis_tlast_o,
   output logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata_o,
   input  logic                              m_axis_tready_i,
   output logic                              grant_valid_o,
   output logic [GRANT_W-1:0]                grant_o
);

   arb_state_e                 r_state;
   arb_state_e                 w_state_nxt;
   logic [GRANT_W-1:0]         r_grant;
   logic [GRANT_W-1:0]         r_last_grant;

   logic [NUM_CH-1:0]          w_req;
   logic                       w_pick_valid;
   logic [GRANT_W-1:0]         w_pick_idx;
   logic                       w_load;
   logic                       w_sel_valid;
   logic                       w_sel_last;
   logic [AXIS_DATA_WIDTH-1:0] w_sel_data;
   logic                       w_release_ok;

   // The mask only gates who may win an arbitration; it never touches a
   // grant that is already held.
   assign w_req = s_axis_tvalid_i & ch_enable_i;

   axis_rr_picker #(
      .NUM_CH       (NUM_CH)
   ) u_picker (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_pick_valid (w_pick_valid),
      .o_pick_idx   (w_pick_idx)
   );

   // Source mux of the granted channel.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (r_grant == GRANT_W'(k)) begin
            w_sel_valid = s_axis_tvalid_i[k];
            w_sel_last  = s_axis_tlast_i[k];
            w_sel_data  = s_axis_tdata_i[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
         end
      end
   end

`ifdef AXIS_ARB_PKT_LOCK_EN
   // Packet-atomic: only the final beat of a packet frees the sink.
   assign w_release_ok = w_sel_last;
`else
   // Beat interleave: any transfer frees the sink; tlast is only forwarded.
   assign w_release_ok = 1'b1;
`endif

   // Next state and outputs. All stream outputs are zero outside GRANT and
   // derive from registered state, so reset clears them without a clock edge.
   always_comb begin
      w_state_nxt     = r_state;
      w_load          = 1'b0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      m_axis_tdata_o  = '0;
      s_axis_tready_o = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = ARB_GRANT;
               w_load      = 1'b1;
            end
         end
         ARB_GRANT: begin
            m_axis_tvalid_o = w_sel_valid;
            m_axis_tlast_o  = w_sel_last;
            m_axis_tdata_o  = w_sel_data;
            s_axis_tready_o = NUM_CH'(m_axis_tready_i) << r_grant;
            // A granted source that drops tvalid simply keeps the grant.
            if (w_sel_valid && m_axis_tready_i && w_release_ok) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // last_grant starts at NUM_CH-1 so channel 0 is searched first.
   always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
      if (!axis_aresetn_i) begin
         r_state      <= ARB_IDLE;
         r_grant      <= '0;
         r_last_grant <= GRANT_W'(NUM_CH - 1);
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
         if (w_load) begin
            r_grant      <= w_pick_idx;
            r_last_grant <= w_pick_idx;
         end
      end
   end

   assign grant_valid_o = (r_state == ARB_GRANT);
   assign grant_o       = r_grant;

endmodule : axis_rr_arbiter

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Self-checking bench for axis_rr_arbiter (NUM_CH=4, 8-bit data). Sources are
// per-channel beat queues; a cycle-level reference model (owner channel,
// last winner, rotating search by modulo arithmetic) predicts every output.
// Honours AXIS_ARB_PKT_LOCK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

   localparam int N = 4;
   localparam int W = 8;
`ifdef AXIS_ARB_PKT_LOCK_EN
   localparam bit PKT_LOCK = 1'b1;
`else
   localparam bit PKT_LOCK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   en;
   logic [N-1:0]   s_tvalid;
   logic [N-1:0]   s_tlast;
   logic [N*W-1:0] s_tdata;
   logic [N-1:0]   s_tready;
   logic           m_tvalid;
   logic           m_tlast;
   logic [W-1:0]   m_tdata;
   logic           m_tready;
   logic           gv;
   logic [1:0]     gnt;

   always #5 clk = ~clk;

   axis_rr_arbiter #(
      .NUM_CH          (N),
      .AXIS_DATA_WIDTH (W)
   ) dut (
      .axis_aclk_i     (clk),
      .axis_aresetn_i  (rst_n),
      .ch_enable_i     (en),
      .s_axis_tvalid_i (s_tvalid),
      .s_axis_tlast_i  (s_tlast),
      .s_axis_tdata_i  (s_tdata),
      .s_axis_tready_o (s_tready),
      .m_axis_tvalid_o (m_tvalid),
      .m_axis_tlast_o  (m_tlast),
      .m_axis_tdata_o  (m_tdata),
      .m_axis_tready_i (m_tready),
      .grant_valid_o   (gv),
      .grant_o         (gnt)
   );

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [8:0]   q [N][$];     // pending beats per source: {last, data}
   logic [N-1:0] gate;         // 0 forces a source's tvalid low
   int           act_log[$];   // observed transfers: ch*512 + last*256 + data
   logic [N-1:0] rec_ready;
   logic         s_gv;
   bit           rand_mode = 1'b0;

   // reference model
   int mdl_owner;              // -1 when no channel holds the sink
   int mdl_last_grant;
   int mdl_grant;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      mdl_owner      = -1;
      mdl_last_grant = N - 1;
      mdl_grant      = 0;
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (q[k].size() > 0) begin
            s_tvalid[k] = gate[k];
            {s_tlast[k], s_tdata[k*W +: W]} = q[k][0];
         end else begin
            s_tvalid[k]       = 1'b0;
            s_tlast[k]        = 1'b0;
            s_tdata[k*W +: W] = '0;
         end
      end
   endtask

   task automatic clear_all();
      for (int k = 0; k < N; k++) q[k].delete();
      act_log.delete();
   endtask

   // One clock: entered and left at posedge+1 with inputs stable.
   task automatic step();
      logic         ev, el;
      logic [W-1:0] ed;
      logic [N-1:0] er;
      int           p;
      @(negedge clk);
      ev = 1'b0; el = 1'b0; ed = '0; er = '0;
      if (mdl_owner >= 0) begin
         ev = s_tvalid[mdl_owner];
         el = s_tlast[mdl_owner];
         ed = s_tdata[mdl_owner*W +: W];
         er = N'(m_tready) << mdl_owner;
      end
      check("grant_valid", gv, (mdl_owner >= 0));
      check("grant", gnt, mdl_grant);
      check("m_tvalid", m_tvalid, ev);
      check("m_tlast", m_tlast, el);
      check("m_tdata", m_tdata, ed);
      check("s_tready", s_tready, er);
      s_gv      = gv;
      rec_ready = s_tready;
      if (m_tvalid && m_tready) act_log.push_back(int'(gnt)*512 + int'(m_tlast)*256 + int'(m_tdata));
      @(posedge clk);
      if (mdl_owner < 0) begin
         p = rr_pick(s_tvalid & en, mdl_last_grant);
         if (p >= 0) begin
            mdl_owner      = p;
            mdl_last_grant = p;
            mdl_grant      = p;
         end
      end else if (s_tvalid[mdl_owner] && m_tready && (PKT_LOCK ? s_tlast[mdl_owner] : 1'b1)) begin
         mdl_owner = -1;
      end
      #1;
      for (int k = 0; k < N; k++) begin
         if (rec_ready[k] && s_tvalid[k] && q[k].size() > 0) void'(q[k].pop_front());
      end
      if (rand_mode) begin
         for (int k = 0; k < N; k++) begin
            if (q[k].size() < 4 && $urandom_range(3) == 0)
               q[k].push_back({($urandom_range(2) == 0), 8'($urandom)});
            gate[k] = ($urandom_range(15) != 0);
         end
         m_tready = ($urandom_range(3) != 0);
         if ($urandom_range(15) == 0) en = N'($urandom);
      end
      drive();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clear_all();
      model_reset();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int  exp_lock [5];
      int  exp_intl [5];
      int  n2;
      int  n1;
      bit  cleared;
      bit  found;

      rst_n    = 1'b0;
      en       = '1;
      gate     = '1;
      m_tready = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      model_reset();
      drive();
      #12;
      check("rst_grant_valid", gv, 0);
      check("rst_grant", gnt, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_s_tready", s_tready, 0);

      // ---- channels 0 and 2, tlast on every beat, sink ready ----
      for (int i = 0; i < 8; i++) begin
         q[0].push_back({1'b1, 8'(8'h00 + i)});
         q[2].push_back({1'b1, 8'(8'h20 + i)});
      end
      m_tready = 1'b1;
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("t1_latency_idle", s_gv, 0);
      step();
      check("t1_latency_grant", s_gv, 1);
      for (int i = 0; i < 38; i++) step();
      check("t1_count", act_log.size(), 16);
      if (act_log.size() >= 4) begin
         check("t1_order0", act_log[0] / 512, 0);
         check("t1_order1", act_log[1] / 512, 2);
         check("t1_order2", act_log[2] / 512, 0);
         check("t1_order3", act_log[3] / 512, 2);
      end

      // ---- 3-beat packet on ch1 while ch3 requests ----
      do_reset();
      q[1].push_back({1'b0, 8'h11});
      q[1].push_back({1'b0, 8'h22});
      q[1].push_back({1'b1, 8'h33});
      q[3].push_back({1'b1, 8'hA1});
      q[3].push_back({1'b1, 8'hA2});
      m_tready = 1'b1;
      drive();
      for (int i = 0; i < 20; i++) step();
      exp_lock = '{1*512 + 8'h11, 1*512 + 8'h22, 1*512 + 256 + 8'h33,
                   3*512 + 256 + 8'hA1, 3*512 + 256 + 8'hA2};
      exp_intl = '{1*512 + 8'h11, 3*512 + 256 + 8'hA1, 1*512 + 8'h22,
                   3*512 + 256 + 8'hA2, 1*512 + 256 + 8'h33};
      check("t2_count", act_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < act_log.size())
            check($sformatf("t2_beat%0d", i), act_log[i], PKT_LOCK ? exp_lock[i] : exp_intl[i]);
      end

      // ---- mask 1011, then clear bit 1 mid-packet ----
      do_reset();
      en = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         q[0].push_back({1'b1, 8'(8'h40 + i)});
         q[1].push_back({(i == 2), 8'(8'h50 + i)});
         q[2].push_back({1'b1, 8'(8'h60 + i)});
         q[3].push_back({1'b1, 8'(8'h70 + i)});
      end
      drive();
      cleared = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         n1 = 0;
         foreach (act_log[j]) if (act_log[j] / 512 == 1) n1++;
         if (!cleared && n1 == 1) begin
            en      = 4'b1001;
            cleared = 1'b1;
         end
      end
      n2 = 0;
      foreach (act_log[j]) if (act_log[j] / 512 == 2) n2++;
      check("t3_mask_cleared", cleared, 1);
      check("t3_ch2_never", n2, 0);
      check("t3_ch1_left", q[1].size(), PKT_LOCK ? 0 : 2);
      check("t3_ch0_left", q[0].size(), 0);
      check("t3_ch3_left", q[3].size(), 0);

      // ---- sink stall for 5 cycles during a grant ----
      do_reset();
      en       = '1;
      m_tready = 1'b0;
      q[0].push_back({1'b0, 8'h51});
      q[0].push_back({1'b1, 8'h52});
      drive();
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_stall_held", s_gv, 1);
      end
      m_tready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("t4_count", act_log.size(), 2);
      if (act_log.size() == 2) begin
         check("t4_beat0", act_log[0], 8'h51);
         check("t4_beat1", act_log[1], 256 + 8'h52);
      end

      // ---- reset pulsed mid-packet on ch2 ----
      do_reset();
      for (int i = 0; i < 4; i++) q[2].push_back({(i == 3), 8'(8'h80 + i)});
      drive();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (act_log.size() > 0) found = 1'b1;
      end
      check("t5_wait_beat", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_gv", gv, 0);
      check("t5_async_grant", gnt, 0);
      check("t5_async_m_tvalid", m_tvalid, 0);
      check("t5_async_m_tlast", m_tlast, 0);
      check("t5_async_m_tdata", m_tdata, 0);
      check("t5_async_s_tready", s_tready, 0);
      clear_all();
      model_reset();
      q[0].push_back({1'b1, 8'h0C});
      q[2].push_back({1'b1, 8'h2C});
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("t5_first_count", (act_log.size() > 0), 1);
      if (act_log.size() > 0) check("t5_first_ch0", act_log[0] / 512, 0);

      // ---- randomized traffic against the model ----
      do_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 3000; i++) step();
      rand_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_axis_rr_arbiter
